sp_dispatch: RTL and testbench

Scratchpad-side receiver for the datapath's scratchpad instruction port. Buffers `instrFIFO_t` words written by the datapath (`sp_write`/`sp_out`) in an internal FIFO, issues them in order to the load, GEMM and store engines through a req/done handshake, and returns the one-cycle `load_complete`, `gemm_complete` and `store_complete` pulses the datapath waits on. Sits at the scratchpad top, between the datapath/cache interface and the three engines.

---
 rtl/sp_types_pkg.sv | 25 ++
 rtl/sp_dispatch.sv | 222 ++++++++++++++++++++++
 tb/tb_sp_dispatch.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_types_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sp_types_pkg
// Purpose  : Instruction word carried on the datapath -> scratchpad
//            instruction port, and its opcode encoding.
// Contents : spop_t       - 3-bit opcode
//            c_OP_*       - LOAD / STORE / GEMM encodings (all others invalid)
//            instrFIFO_t  - { op[2:0], payload[28:0] } = 32-bit word
// Revision : 1.0 - initial release
// ============================================================================
package sp_types_pkg;

  typedef logic [2:0] spop_t;

  localparam spop_t c_OP_LOAD  = 3'd1;
  localparam spop_t c_OP_STORE = 3'd2;
  localparam spop_t c_OP_GEMM  = 3'd3;

  typedef struct packed {
    spop_t       op;
    logic [28:0] payload;
  } instrFIFO_t;

endpackage
`default_nettype wire

// File: rtl/sp_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : sp_dispatch
// Purpose  : Scratchpad-side receiver for the datapath instruction port.
//            Buffers instrFIFO_t words in a DEPTH-entry FIFO and issues them
//            strictly in order, one at a time, to the load / GEMM / store
//            engines over a req/done handshake, returning one-cycle
//            completion pulses to the datapath.
// Ports    : CLK, nRST (sync, active-low)
//            sp_write/sp_out          - enqueue strobe and instruction word
//            fifo_full, overflow      - FIFO status (overflow is sticky)
//            bad_op                   - pulse: dequeued op not LOAD/STORE/GEMM
//            {ld,gemm,st}_req/_instr  - engine request + held instruction
//            {ld,gemm,st}_done        - engine done strobes
//            load/gemm/store_complete - one-cycle completion pulses
//            busy                     - FIFO non-empty or dispatcher active
// Options  : SP_DISPATCH_STATS_EN adds saturating 16-bit issue counters
//            n_load, n_gemm, n_store.
// Revision : 1.0 - initial release
// ============================================================================
module sp_dispatch
  import sp_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        sp_write,
  input  instrFIFO_t  sp_out,
  output logic        fifo_full,
  output logic        overflow,
  output logic        bad_op,
  output logic        ld_req,
  output logic        gemm_req,
  output logic        st_req,
  output instrFIFO_t  ld_instr,
  output instrFIFO_t  gemm_instr,
  output instrFIFO_t  st_instr,
  input  logic        ld_done,
  input  logic        gemm_done,
  input  logic        st_done,
  output logic        load_complete,
  output logic        gemm_complete,
  output logic        store_complete,
`ifdef SP_DISPATCH_STATS_EN
  output logic [15:0] n_load,
  output logic [15:0] n_gemm,
  output logic [15:0] n_store,
`endif
  output logic        busy
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  instrFIFO_t      fifo_q [DEPTH];
  logic [c_AW-1:0] wptr_q, rptr_q;
  logic [c_CW-1:0] count_q, count_d;
  logic            w_pop, w_push, w_drop, w_done;

  state_t          state_q;
  instrFIFO_t      issue_q, ld_instr_q, gemm_instr_q, st_instr_q;
  logic            ld_req_q, gemm_req_q, st_req_q;
  logic            ld_cmp_q, gemm_cmp_q, st_cmp_q;
  logic            bad_op_q, overflow_q, full_q, busy_q;

  // A write is accepted when full as long as IDLE pops the head that cycle.
  always_comb begin
    w_pop   = (state_q == S_IDLE) && (count_q != '0);
    w_push  = sp_write && ((count_q != c_FULL) || w_pop);
    w_drop  = sp_write && !w_push;
    // Only the engine that holds a request can finish it.
    w_done  = (ld_req_q && ld_done) || (gemm_req_q && gemm_done) ||
              (st_req_q && st_done);
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CW'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - c_CW'(1);
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (nRST && w_push) begin
      fifo_q[wptr_q] <= sp_out;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) wptr_q <= wptr_q + c_AW'(1);
      if (w_pop)  rptr_q <= rptr_q + c_AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == c_FULL);
      if (w_drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      issue_q      <= '0;
      ld_instr_q   <= '0;
      gemm_instr_q <= '0;
      st_instr_q   <= '0;
      ld_req_q     <= 1'b0;
      gemm_req_q   <= 1'b0;
      st_req_q     <= 1'b0;
      ld_cmp_q     <= 1'b0;
      gemm_cmp_q   <= 1'b0;
      st_cmp_q     <= 1'b0;
      bad_op_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bad_op_q   <= 1'b0;
      ld_cmp_q   <= 1'b0;
      gemm_cmp_q <= 1'b0;
      st_cmp_q   <= 1'b0;
      busy_q     <= (count_d != '0);
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            issue_q <= fifo_q[rptr_q];
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          busy_q  <= 1'b1;
          case (issue_q.op)
            c_OP_LOAD: begin
              ld_req_q   <= 1'b1;
              ld_instr_q <= issue_q;
            end
            c_OP_GEMM: begin
              gemm_req_q   <= 1'b1;
              gemm_instr_q <= issue_q;
            end
            c_OP_STORE: begin
              st_req_q   <= 1'b1;
              st_instr_q <= issue_q;
            end
            default: begin
              bad_op_q <= 1'b1;
              state_q  <= S_IDLE;
              busy_q   <= (count_d != '0);
            end
          endcase
        end
        S_WAIT: begin
          if (w_done) begin
            ld_req_q   <= 1'b0;
            gemm_req_q <= 1'b0;
            st_req_q   <= 1'b0;
            ld_cmp_q   <= ld_req_q;
            gemm_cmp_q <= gemm_req_q;
            st_cmp_q   <= st_req_q;
            state_q    <= S_IDLE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SP_DISPATCH_STATS_EN
  logic [15:0] n_load_q, n_gemm_q, n_store_q;

  // Counted at the decode step, i.e. once per request actually raised.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      n_load_q  <= '0;
      n_gemm_q  <= '0;
      n_store_q <= '0;
    end else if (state_q == S_ISSUE) begin
      if (issue_q.op == c_OP_LOAD && n_load_q != 16'hFFFF)
        n_load_q <= n_load_q + 16'd1;
      if (issue_q.op == c_OP_GEMM && n_gemm_q != 16'hFFFF)
        n_gemm_q <= n_gemm_q + 16'd1;
      if (issue_q.op == c_OP_STORE && n_store_q != 16'hFFFF)
        n_store_q <= n_store_q + 16'd1;
    end
  end

  assign n_load  = n_load_q;
  assign n_gemm  = n_gemm_q;
  assign n_store = n_store_q;
`endif

  assign fifo_full      = full_q;
  assign overflow       = overflow_q;
  assign bad_op         = bad_op_q;
  assign ld_req         = ld_req_q;
  assign gemm_req       = gemm_req_q;
  assign st_req         = st_req_q;
  assign ld_instr       = ld_instr_q;
  assign gemm_instr     = gemm_instr_q;
  assign st_instr       = st_instr_q;
  assign load_complete  = ld_cmp_q;
  assign gemm_complete  = gemm_cmp_q;
  assign store_complete = st_cmp_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_dispatch
// Purpose  : Self-checking bench for sp_dispatch. A timeline reference model
//            (instruction queue + "dispatcher free at edge N" bookkeeping
//            derived from the documented latencies) schedules engine done
//            strobes and pushes expected events; a negedge monitor pops and
//            compares them against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_dispatch;
  import sp_types_pkg::*;

  localparam int DEPTH  = 4;
  localparam int EV_REQ = 0;
  localparam int EV_BAD = 1;
  localparam int EV_CMP = 2;

  logic       CLK = 1'b0, nRST = 1'b0, sp_write = 1'b0;
  instrFIFO_t sp_out = '0;
  logic       fifo_full, overflow, bad_op, ld_req, gemm_req, st_req;
  instrFIFO_t ld_instr, gemm_instr, st_instr;
  logic       ld_done = 1'b0, gemm_done = 1'b0, st_done = 1'b0;
  logic       load_complete, gemm_complete, store_complete, busy;
`ifdef SP_DISPATCH_STATS_EN
  logic [15:0] n_load, n_gemm, n_store;
`endif

  sp_dispatch #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .sp_write(sp_write), .sp_out(sp_out),
    .fifo_full(fifo_full), .overflow(overflow), .bad_op(bad_op),
    .ld_req(ld_req), .gemm_req(gemm_req), .st_req(st_req),
    .ld_instr(ld_instr), .gemm_instr(gemm_instr), .st_instr(st_instr),
    .ld_done(ld_done), .gemm_done(gemm_done), .st_done(st_done),
    .load_complete(load_complete), .gemm_complete(gemm_complete),
    .store_complete(store_complete),
`ifdef SP_DISPATCH_STATS_EN
    .n_load(n_load), .n_gemm(n_gemm), .n_store(n_store),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n++;

  typedef struct { int cyc; int kind; int eng; instrFIFO_t word; } ev_t;
  typedef struct { int cyc; bit rst; bit full; bit ovf; bit busy; int cnt[3]; } st_t;

  ev_t evq[$];
  st_t stq[$];
  int  n_vec = 0, n_err = 0;
  bit  mon_on = 1'b1;

  // Reference model state
  instrFIFO_t mq[$];
  bit         m_ovf = 1'b0;
  int         free_edge = 1, done_edge = -1, done_eng = 0, wait_lo = 0;
  int         delay_q[$];
  int         m_cnt[3] = '{0, 0, 0};
  int         spur_pct = 25;

  function automatic int eng_of(input spop_t op);
    if (op == c_OP_LOAD)  return 0;
    if (op == c_OP_GEMM)  return 1;
    if (op == c_OP_STORE) return 2;
    return -1;
  endfunction

  function automatic instrFIFO_t mk(input spop_t op);
    instrFIFO_t w;
    w.op      = op;
    w.payload = 29'($urandom);
    return w;
  endfunction

  function automatic instrFIFO_t rnd_word();
    int v;
    v = $urandom_range(0, 9);
    if (v < 8) return mk(spop_t'(1 + v % 3));
    v = $urandom_range(0, 4);
    return mk(spop_t'((v == 0) ? 0 : 3 + v));
  endfunction

  // Model one clock edge, drive the inputs for it, then advance past it.
  task automatic step(input bit rst, input bit wr, input instrFIFO_t w,
                      input logic [2:0] xdn);
    int         e, k, dly;
    bit         in_wait;
    logic [2:0] dn;
    instrFIFO_t h;
    st_t        s;
    e  = edge_n + 1;
    dn = xdn;
    if (rst) begin
      mq.delete();
      m_ovf     = 1'b0;
      free_edge = e + 1;
      done_edge = -1;
      m_cnt     = '{0, 0, 0};
      for (int i = evq.size() - 1; i >= 0; i--)
        if (evq[i].cyc >= e) evq.delete(i);
      for (int j = 0; j < 3; j++)
        if ($urandom_range(0, 99) < spur_pct) dn[j] = 1'b1;
    end else begin
      in_wait = (done_edge >= 0) && (e >= wait_lo) && (e <= done_edge);
      for (int j = 0; j < 3; j++)
        if ($urandom_range(0, 99) < spur_pct && !(in_wait && j == done_eng))
          dn[j] = 1'b1;
      if (done_edge == e) begin
        dn[done_eng] = 1'b1;
        done_edge    = -1;
      end
      if (free_edge <= e && mq.size() > 0) begin
        h = mq.pop_front();
        k = eng_of(h.op);
        if (k < 0) begin
          evq.push_back('{e + 1, EV_BAD, 0, '0});
          free_edge = e + 2;
        end else begin
          dly = (delay_q.size() > 0) ? delay_q.pop_front() : $urandom_range(1, 6);
          evq.push_back('{e + 1, EV_REQ, k, h});
          evq.push_back('{e + 1 + dly, EV_CMP, k, '0});
          done_edge = e + 1 + dly;
          done_eng  = k;
          wait_lo   = e + 2;
          free_edge = e + 2 + dly;
          if (m_cnt[k] < 65535) m_cnt[k]++;
        end
      end
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1'b1;
      end
    end
    s.cyc  = e;
    s.rst  = rst;
    s.full = (mq.size() == DEPTH);
    s.ovf  = m_ovf;
    s.busy = (mq.size() != 0) || (free_edge > e + 1);
    s.cnt  = m_cnt;
    stq.push_back(s);
    nRST     = !rst;
    sp_write = wr;
    sp_out   = w;
    {st_done, gemm_done, ld_done} = dn;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 3'b000);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (mq.size() > 0 || free_edge > edge_n + 1); i++)
      step(1'b0, 1'b0, '0, 3'b000);
    idle(2);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int eng, input instrFIFO_t w,
                         input int c);
    n_vec++;
    if (evq.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event cyc=%0d got kind=%0d eng=%0d exp none",
               c, kind, eng);
    end else if (evq[0].cyc == c && evq[0].kind == kind && evq[0].eng == eng &&
                 (kind != EV_REQ || w == evq[0].word)) begin
      void'(evq.pop_front());
    end else begin
      n_err++;
      $display("FAIL event cyc=%0d got kind=%0d eng=%0d word=%0h exp cyc=%0d kind=%0d eng=%0d word=%0h",
               c, kind, eng, w, evq[0].cyc, evq[0].kind, evq[0].eng, evq[0].word);
      if (evq[0].cyc == c) void'(evq.pop_front());
    end
  endtask

  logic [2:0] prev_r = 3'b000;

  task automatic check_cycle();
    int         c;
    logic [2:0] r, cm;
    instrFIFO_t iw [3];
    st_t        s;
    c  = edge_n;
    r  = {st_req, gemm_req, ld_req};
    cm = {store_complete, gemm_complete, load_complete};
    iw[0] = ld_instr; iw[1] = gemm_instr; iw[2] = st_instr;
    if (stq.size() > 0 && stq[0].cyc == c) begin
      s = stq.pop_front();
      chk("fifo_full", c, 32'(fifo_full), 32'(s.full));
      chk("overflow", c, 32'(overflow), 32'(s.ovf));
      chk("busy", c, 32'(busy), 32'(s.busy));
      if (s.rst) begin
        chk("rst_outputs", c, {25'd0, r, cm, bad_op}, 32'd0);
        chk("rst_instr", c, ld_instr | gemm_instr | st_instr, 32'd0);
      end
`ifdef SP_DISPATCH_STATS_EN
      chk("n_load", c, 32'(n_load), 32'(s.cnt[0]));
      chk("n_gemm", c, 32'(n_gemm), 32'(s.cnt[1]));
      chk("n_store", c, 32'(n_store), 32'(s.cnt[2]));
`endif
    end
    while (evq.size() > 0 && evq[0].cyc < c) begin
      n_vec++; n_err++;
      $display("FAIL missing_event cyc=%0d got none exp kind=%0d eng=%0d at cyc=%0d",
               c, evq[0].kind, evq[0].eng, evq[0].cyc);
      void'(evq.pop_front());
    end
    for (int k = 0; k < 3; k++)
      if (r[k] && !prev_r[k]) observe(EV_REQ, k, iw[k], c);
    if (bad_op) observe(EV_BAD, 0, '0, c);
    for (int k = 0; k < 3; k++)
      if (cm[k]) begin
        observe(EV_CMP, k, '0, c);
        chk("req_dropped_at_complete", c, 32'(r[k]), 32'd0);
      end
    if (evq.size() > 0 && evq[0].cyc == c) begin
      n_vec++; n_err++;
      $display("FAIL missing_event cyc=%0d got none exp kind=%0d eng=%0d",
               c, evq[0].kind, evq[0].eng);
      void'(evq.pop_front());
    end
    chk("reqs_onehot", c, 32'($countones(r) <= 1), 32'd1);
    prev_r = r;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_on) check_cycle();
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, '0, 3'b000);
    // Single LOAD, done 5 cycles after req rises.
    delay_q.push_back(5);
    step(1'b0, 1'b1, mk(c_OP_LOAD), 3'b000);
    drain();
    // Back-to-back LOAD, GEMM, STORE, each done after 3 cycles.
    repeat (3) delay_q.push_back(3);
    step(1'b0, 1'b1, mk(c_OP_LOAD), 3'b000);
    step(1'b0, 1'b1, mk(c_OP_GEMM), 3'b000);
    step(1'b0, 1'b1, mk(c_OP_STORE), 3'b000);
    drain();
    // Stalled LOAD, six writes: four queue up, the sixth overflows.
    delay_q.push_back(30);
    step(1'b0, 1'b1, mk(c_OP_LOAD), 3'b000);
    repeat (5) step(1'b0, 1'b1, rnd_word(), 3'b000);
    drain();
    // Refill to full, then write in the very cycle IDLE pops.
    step(1'b1, 1'b0, '0, 3'b000);
    delay_q.push_back(12);
    step(1'b0, 1'b1, mk(c_OP_LOAD), 3'b000);
    repeat (4) step(1'b0, 1'b1, rnd_word(), 3'b000);
    for (int i = 0; i < 50 && free_edge > edge_n + 1; i++) idle(1);
    step(1'b0, 1'b1, mk(c_OP_GEMM), 3'b000);
    drain();
    // Unknown op, then a LOAD that must still issue.
    step(1'b0, 1'b1, mk(3'd5), 3'b000);
    step(1'b0, 1'b1, mk(c_OP_LOAD), 3'b000);
    drain();
    // Reset during GEMM WAIT, stray gemm_done right after.
    delay_q.push_back(10);
    step(1'b0, 1'b1, mk(c_OP_GEMM), 3'b000);
    idle(5);
    step(1'b1, 1'b0, '0, 3'b000);
    step(1'b0, 1'b0, '0, 3'b010);
    idle(3);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) step(1'b1, 1'b0, '0, 3'b000);
      else step(1'b0, ($urandom_range(0, 99) < 45), rnd_word(), 3'b000);
    end
    drain();
    @(negedge CLK);
    #1;
    mon_on = 1'b0;
    chk("leftover_events", edge_n, 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
